// File: rtl/wb_loader_pkg.sv
`default_nettype none
//============================================================================
// Module   : wb_loader_pkg
// Desc     : Shared types and constants for the stream-to-Wishbone loader.
// Revision : 1.0 - initial release
//============================================================================
package wb_loader_pkg;

   localparam int LANES = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COLLECT  = 3'd1,
      WRITE    = 3'd2,
      WAIT_ACK = 3'd3,
      DONE     = 3'd4,
      ERROR    = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_byte_packer.sv
`default_nettype none
//============================================================================
// Module   : wb_byte_packer
// Desc     : Packs accepted bytes little-endian into one word with lane selects.
// Revision : 1.0 - initial release
//============================================================================
module wb_byte_packer
   import wb_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               accept,
   input  logic [7:0]         byte_in,
   input  logic               last_in,
   output logic [8*LANES-1:0] word_data,
   output logic [LANES-1:0]   word_sel,
   output logic               word_ready,
   output logic               last_flag
);

   localparam int c_lane_w = $clog2(LANES);

   logic [c_lane_w-1:0] r_lane;
   logic [8*LANES-1:0]  r_data;
   logic [LANES-1:0]    r_sel;
   logic                r_last;

   // Unfilled lanes stay zero because clear wipes the whole word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane <= '0;
         r_data <= '0;
         r_sel  <= '0;
         r_last <= 1'b0;
      end else if (clear) begin
         r_lane <= '0;
         r_data <= '0;
         r_sel  <= '0;
         r_last <= 1'b0;
      end else if (accept) begin
         for (int k = 0; k < LANES; k++) begin
            if (r_lane == c_lane_w'(k)) begin
               r_data[8*k +: 8] <= byte_in;
               r_sel[k]         <= 1'b1;
            end
         end
         r_lane <= r_lane + 1'b1;
         if (last_in)
            r_last <= 1'b1;
      end
   end

   assign word_ready = accept & ((r_lane == c_lane_w'(LANES-1)) | last_in);
   assign word_data  = r_data;
   assign word_sel   = r_sel;
   assign last_flag  = r_last;

endmodule
`default_nettype wire

// File: rtl/wb_stream_loader.sv
`default_nettype none
//============================================================================
// Module   : wb_stream_loader
// Desc     : Byte stream to pipelined Wishbone B4 single-write RAM loader.
// Revision : 1.0 - initial release
//============================================================================
module wb_stream_loader
   import wb_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 16384,
   parameter int          CWIDTH      = $clog2(DEPTH_WORDS) + 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CWIDTH-1:0] word_count,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [31:0]       wb_adr_o,
   output logic [3:0]        wb_sel_o,
   output logic [31:0]       wb_dat_o,
   input  logic              wb_ack_i,
   input  logic              wb_stall_i,
   input  logic              wb_err_i
);

   state_t              r_state;
   state_t              w_next;
   logic [CWIDTH-1:0]   r_word_idx;
   logic [31:0]         r_adr;
   logic                w_load_clear;
   logic                w_word_done;
   logic                w_accept;
   logic                w_word_ready;
   logic                w_last_flag;
   logic                w_full;

   assign w_full = (r_word_idx == CWIDTH'(DEPTH_WORDS));

   wb_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (w_load_clear | w_word_done),
      .accept     (w_accept),
      .byte_in    (s_data),
      .last_in    (s_last),
      .word_data  (wb_dat_o),
      .word_sel   (wb_sel_o),
      .word_ready (w_word_ready),
      .last_flag  (w_last_flag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      s_ready      = 1'b0;
      wb_cyc_o     = 1'b0;
      wb_stb_o     = 1'b0;
      wb_we_o      = 1'b0;
      w_load_clear = 1'b0;
      w_word_done  = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         IDLE, DONE, ERROR: begin
            if (start) begin
               w_next       = COLLECT;
               w_load_clear = 1'b1;
            end
         end
         COLLECT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               // Past the end of RAM the byte is swallowed so the source never stalls.
               if (w_full) begin
                  w_next = ERROR;
               end else begin
                  w_accept = 1'b1;
                  if (w_word_ready)
                     w_next = WRITE;
               end
            end
         end
         WRITE: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = 1'b1;
            if (wb_err_i) begin
               w_next = ERROR;
            end else if (!wb_stall_i) begin
               if (wb_ack_i) begin
                  w_word_done = 1'b1;
                  w_next      = w_last_flag ? DONE : COLLECT;
               end else begin
                  w_next = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            wb_cyc_o = 1'b1;
            wb_we_o  = 1'b1;
            if (wb_err_i) begin
               w_next = ERROR;
            end else if (wb_ack_i) begin
               w_word_done = 1'b1;
               w_next      = w_last_flag ? DONE : COLLECT;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_idx <= '0;
         r_adr      <= '0;
      end else if (w_load_clear) begin
         r_word_idx <= '0;
         r_adr      <= BASE_ADDR;
      end else if (w_word_done) begin
         r_word_idx <= r_word_idx + 1'b1;
         r_adr      <= r_adr + 32'd4;
      end
   end

   assign word_count = r_word_idx;
   assign wb_adr_o   = r_adr;
   assign busy       = (r_state == COLLECT) | (r_state == WRITE) | (r_state == WAIT_ACK);
   assign done       = (r_state == DONE);
   assign error      = (r_state == ERROR);

endmodule
`default_nettype wire

// File: tb/tb_wb_stream_loader.sv
`default_nettype none
//============================================================================
// Module   : tb_wb_stream_loader
// Desc     : Scoreboard bench for wb_stream_loader with a pipelined RAM slave.
// Revision : 1.0 - initial release
//============================================================================
module tb_wb_stream_loader;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready, busy, done, error;
   logic [CW-1:0] word_count;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0]   wb_adr_o, wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_ack_i = 1'b0;
   logic          wb_stall_i = 1'b0;
   logic          wb_err_i = 1'b0;

   always #5 clk = ~clk;

   wb_stream_loader #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_sel_o   (wb_sel_o),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_i   (wb_ack_i),
      .wb_stall_i (wb_stall_i),
      .wb_err_i   (wb_err_i)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected write requests: {adr, dat, sel}
   logic [67:0] sb_q[$];

   int          m_lane;
   int          m_idx;
   logic [31:0] m_dat;
   logic [3:0]  m_sel;
   logic [31:0] m_adr;

   task automatic model_reset();
      m_lane = 0; m_idx = 0; m_dat = '0; m_sel = '0; m_adr = 32'h0;
   endtask

   task automatic model_byte(input logic [7:0] d, input bit l);
      if (m_idx >= DEPTH) return;
      m_dat[8*m_lane +: 8] = d;
      m_sel[m_lane] = 1'b1;
      m_lane++;
      if (m_lane == 4 || l) begin
         sb_q.push_back({m_adr, m_dat, m_sel});
         m_adr  = m_adr + 32'd4;
         m_idx++;
         m_lane = 0;
         m_dat  = '0;
         m_sel  = '0;
      end
   endtask

   // Slave behaviour knobs and observations
   int stall_left   = 0;
   int err_at       = -1;
   int req_cnt      = 0;
   int stb_cnt      = 0;
   int last_stb_cnt = 0;
   bit pend         = 1'b0;
   bit pend_err     = 1'b0;
   bit err_follow   = 1'b0;

   // RAM slave: acks one cycle after an unstalled strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (err_follow) begin
            chk("cyc_after_err", wb_cyc_o, 0);
            err_follow = 1'b0;
         end
         wb_ack_i = pend & !pend_err;
         wb_err_i = pend & pend_err;
         if (pend && pend_err) err_follow = 1'b1;
         pend = 1'b0;
         if (wb_stb_o === 1'b1) begin
            stb_cnt++;
            chk("s_ready_in_write", s_ready, 0);
            chk("we_in_write", wb_we_o, 1);
            if (sb_q.size() == 0) begin
               chk("unexpected_req", wb_stb_o, 0);
            end else begin
               chk("adr", wb_adr_o, sb_q[0][67:36]);
               chk("dat", wb_dat_o, sb_q[0][35:4]);
               chk("sel", wb_sel_o, sb_q[0][3:0]);
            end
            if (stall_left > 0) begin
               wb_stall_i = 1'b1;
               stall_left--;
            end else begin
               wb_stall_i   = 1'b0;
               pend         = 1'b1;
               pend_err     = (req_cnt == err_at);
               req_cnt++;
               last_stb_cnt = stb_cnt;
               stb_cnt      = 0;
               if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
         end else begin
            wb_stall_i = 1'b0;
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_reset();
   endtask

   task automatic send_byte(input logic [7:0] d, input bit l, output bit ok);
      int n;
      n = 0;
      s_data = d; s_valid = 1'b1; s_last = l;
      while (s_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = (s_ready === 1'b1);
      if (!ok) chk("s_ready_timeout", s_ready, 1);
      if (ok) begin
         model_byte(d, l);
         @(posedge clk);
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] first, input int cnt, input bit last_at_end);
      bit ok;
      for (int i = 0; i < cnt; i++)
         send_byte(first + 8'(i), last_at_end && (i == cnt - 1), ok);
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (!(done === 1'b1 || error === 1'b1))
         chk({tag, "_timeout"}, {done, error}, 2'b10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_flags", {s_ready, busy, done, error}, 4'b0000);
      chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 7'b0);
      chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
      chk("rst_count", word_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_s_ready", s_ready, 0);

      // Full two-word load
      pulse_start();
      chk("collect_busy", {busy, s_ready}, 2'b11);
      send_seq(8'h01, 8, 1'b1);
      wait_end("full");
      chk("full_done", {done, error, busy}, 3'b100);
      chk("full_count", word_count, 2);

      // Partial tail word
      pulse_start();
      send_byte(8'hAA, 0, ok);
      send_byte(8'hBB, 0, ok);
      send_byte(8'hCC, 0, ok);
      send_byte(8'hDD, 0, ok);
      send_byte(8'hEE, 1, ok);
      wait_end("part");
      chk("part_done", done, 1);
      chk("part_count", word_count, 2);

      // Stalled first write
      stall_left = 3;
      pulse_start();
      send_seq(8'h10, 4, 1'b1);
      wait_end("stall");
      chk("stall_stb_cycles", last_stb_cnt, 4);
      chk("stall_count", word_count, 1);
      chk("stall_done", done, 1);

      // Bus error on the second word, then recovery
      err_at = req_cnt + 1;
      pulse_start();
      send_seq(8'h20, 8, 1'b1);
      wait_end("err");
      chk("err_flag", {error, done}, 2'b10);
      chk("err_count", word_count, 1);
      err_at = -1;
      pulse_start();
      chk("err_cleared", {error, busy}, 2'b01);
      send_seq(8'h30, 4, 1'b1);
      wait_end("reload");
      chk("reload_done", {done, error}, 2'b10);
      chk("reload_count", word_count, 1);

      // Overflow past DEPTH words
      pulse_start();
      send_seq(8'h40, 16, 1'b0);
      send_byte(8'h99, 0, ok);
      chk("ovf_17th_accepted", ok, 1);
      wait_end("ovf");
      chk("ovf_error", {error, done}, 2'b10);
      chk("ovf_count", word_count, 4);
      chk("ovf_no_extra", sb_q.size(), 0);

      // Asynchronous reset while waiting for ack
      pulse_start();
      send_seq(8'h50, 4, 1'b1);
      n = 0;
      while (!(wb_cyc_o === 1'b1 && wb_stb_o === 1'b0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wait_ack", {wb_cyc_o, wb_stb_o}, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_bus", {wb_cyc_o, wb_stb_o, busy}, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {s_ready, busy, done, error}, 4'b0000);
      chk("post_rst_count", word_count, 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_stream_loader.md
Name: wb_stream_loader

Overview:
- Upstream Wishbone master for the on-chip 16384x32 single-port RAM.
- Accepts an 8-bit valid/ready byte stream, e.g. from the UART boot receiver, and packs it little-endian into 32-bit words.
- Writes each word to RAM with pipelined Wishbone B4 single writes from BASE_ADDR upward.
- Used to load program images into RAM before the core leaves reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- DEPTH_WORDS, 16384, number of writable words; must be a power of two.
- CWIDTH, $clog2(DEPTH_WORDS)+1, width of word_count.

Ports:
- clk  in  1  system clock; same clock as the Wishbone bus.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; arms a load. Ignored unless in IDLE, DONE or ERROR.
- s_data  in  8  stream byte.
- s_valid  in  1  byte valid.
- s_last  in  1  qualifies the final byte of the image.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- busy  out  1  load in progress.
- done  out  1  high in DONE state.
- error  out  1  high in ERROR state.
- word_count  out  CWIDTH  words acknowledged since start.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  byte address.
- wb_sel_o  out  4  byte lane select.
- wb_dat_o  out  32  write data.
- wb_ack_i  in  1  acknowledge.
- wb_stall_i  in  1  pipelined stall.
- wb_err_i  in  1  bus error.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE; all outputs 0; byte lane counter 0; word index 0.
- State IDLE
  - s_ready = 0.
  - start -> COLLECT; clears word_count, word index, lane counter and error.
- State COLLECT
  - s_ready = 1.
  - Each accepted byte goes to lane k = lane counter, i.e. data[8k+7:8k]. Lane k's sel bit is set and the counter increments.
  - Lane 3 accepted, or any byte accepted with s_last -> WRITE on the next cycle. The last flag is latched.
  - s_last on lane k<3: sel = lanes 0..k only; unfilled data lanes are 0.
- State WRITE
  - s_ready = 0. wb_cyc_o = wb_stb_o = wb_we_o = 1.
  - wb_adr_o = BASE_ADDR + 4*word index.
  - wb_stb_o stays high while wb_stall_i = 1. The first cycle with wb_stall_i = 0 completes the request -> WAIT_ACK with stb = 0 and cyc held.
  - If ack arrives in the same cycle as an unstalled strobe, the word completes directly.
- State WAIT_ACK
  - wb_cyc_o = 1.
  - On wb_ack_i: word_count and word index increment, lane counter and sel clear. Then -> DONE if the last flag is latched, else -> COLLECT.
  - The RAM acks one cycle after the strobe, so throughput is one word per 6 cycles at full stream rate.
- Only one outstanding request is ever allowed.
- wb_err_i in WRITE or WAIT_ACK -> ERROR; cyc/stb drop the next cycle; word_count is not incremented.
- Overflow: a byte arriving in COLLECT while word index = DEPTH_WORDS -> ERROR. The byte is accepted and discarded so the upstream UART never hangs.
- DONE and ERROR hold until start, which re-arms directly into COLLECT.
- busy = state in {COLLECT, WRITE, WAIT_ACK}.
- wb_dat_o, wb_adr_o and wb_sel_o are registered and stable throughout WRITE.
- Address arithmetic is 32-bit, with no wrap below DEPTH_WORDS.
- start while busy is ignored.
- Reset mid-transfer drops cyc immediately (asynchronous). The partial word is lost.

Decomposition:
- Package wb_loader_pkg holds:
  - enum state_t {IDLE, COLLECT, WRITE, WAIT_ACK, DONE, ERROR};
  - localparam LANES = 4.
- Sub-module wb_byte_packer: lane counter, data/sel assembly and word-ready flag, with a clear input. The FSM and Wishbone master logic stay in the top.

Test Plan:
- Full load: start, then bytes 01 02 03 04 05 06 07 08 with s_last on 08. Required: two writes, adr 0x0/0x4, dat 0x04030201/0x08070605, sel F/F; done=1, word_count=2.
- Partial tail: 5 bytes AA BB CC DD EE with s_last on EE. Required: second write adr 0x4, dat 0x000000EE, sel 4'b0001.
- Stall: slave holds wb_stall_i=1 for 3 cycles on first write. Required: stb high for 4 cycles with adr/dat stable; exactly one ack consumed; s_ready low throughout.
- Error: wb_err_i on second word. Required: error=1, word_count=1, cyc low next cycle. A later start clears error and reloads from BASE_ADDR.
- Overflow with DEPTH_WORDS=4: send 17 bytes. Required: 4 words written, 17th byte accepted (s_ready=1), then error=1.
- Reset: drop rst_n during WAIT_ACK. Required: cyc/stb/busy go to 0 without a clock edge; after release, state is IDLE with s_ready=0.
